// File: rtl/fir_decim_out.sv
// FIR output stage: keeps every DECIM-th valid sample, rounds/shifts/saturates it
// to DOUT_W bits and queues it in a small FIFO behind a valid/ready handshake.
module fir_decim_out #(
  parameter int DIN_W      = 34,
  parameter int DOUT_W     = 16,
  parameter int DECIM      = 4,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIN_W-1:0]              y_in,
  input  logic                          in_valid,
  input  logic                          clear,
  output logic [DOUT_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sat_flag,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0]  PH_LAST = PW'(DECIM - 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  // Half an output LSB; the shift-then-halve form yields 0 cleanly when SHIFT=0.
  localparam logic [DIN_W:0] ROUND_C = ((DIN_W + 1)'(1) << SHIFT) >> 1;

  logic [PW-1:0]     r_phase;
  logic              r_s1_valid;
  logic [DOUT_W-1:0] r_s1_data;
  logic [DOUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_sat_flag;
  logic              r_overflow;

  logic              w_keep;
  logic [DIN_W:0]    w_sum;
  logic [DIN_W:0]    w_scaled;
  logic              w_sat;
  logic [DOUT_W-1:0] w_s1_next;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_keep    = in_valid && (r_phase == '0);
  assign w_sum     = {1'b0, y_in} + ROUND_C;
  assign w_scaled  = w_sum >> SHIFT;
  assign w_sat     = |w_scaled[DIN_W:DOUT_W];
  assign w_s1_next = w_sat ? '1 : w_scaled[DOUT_W-1:0];

  assign out_valid  = (r_count != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_count = r_count;
  assign sat_flag   = r_sat_flag;
  assign overflow   = r_overflow;

  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign w_pop  = out_valid && out_ready;
  assign w_push = r_s1_valid && ((r_count < DEPTH_C) || w_pop);
  assign w_drop = r_s1_valid && !w_push;

  // NOTE: all state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      if (in_valid) begin
        r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
      end
      r_s1_valid <= w_keep;
      if (w_keep) begin
        r_s1_data <= w_s1_next;
      end
    end
  end

  // NOTE: storage array has no reset; out_data is masked to 0 while empty instead.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_s1_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: set event is tested before clear so a coincident event keeps the flag high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sat_flag <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_keep && w_sat) begin
        r_sat_flag <= 1'b1;
      end else if (clear) begin
        r_sat_flag <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out at DECIM=4, SHIFT=8, FIFO_DEPTH=4, DOUT_W=16.
module tb_fir_decim_out;

  logic        clk;
  logic        reset;
  logic [33:0] y_in;
  logic        in_valid;
  logic        clear;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_count;
  logic        sat_flag;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [33:0] Y_MAX = 34'h3_FFFF_FFFF;

  fir_decim_out dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .in_valid   (in_valid),
    .clear      (clear),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .sat_flag   (sat_flag),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; y_in = '0; clear = 1'b0; out_ready = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d exp 0", out_data); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
    n_checks++; if (sat_flag !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got sat=%b ovf=%b exp 0/0", sat_flag, overflow); end
    in_valid = 1'b1; y_in = 34'd4736;
    step(); step();
    n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_held: got valid=%b count=%0d exp 0/0", out_valid, fifo_count); end
    in_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_steady();
    logic exp_v;
    out_ready = 1'b1; in_valid = 1'b1; y_in = 34'd4736;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_v = ((k % 4) == 2);
      n_checks++; if (out_valid !== exp_v) begin n_fail++; $display("FAIL steady_valid edge %0d: got %b exp %b", k, out_valid, exp_v); end
      n_checks++; if (out_data !== (exp_v ? 16'd19 : 16'd0)) begin n_fail++; $display("FAIL steady_data edge %0d: got %0d exp %0d", k, out_data, exp_v ? 19 : 0); end
      n_checks++; if (fifo_count !== (exp_v ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL steady_count edge %0d: got %0d exp %0d", k, fifo_count, exp_v ? 1 : 0); end
    end
    in_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_rounding();
    logic [33:0] vin  [3] = '{34'd383, 34'd384, 34'd0};
    logic [15:0] vexp [3] = '{16'd1, 16'd2, 16'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; y_in = vin[i];
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL round_early %0d: got valid=%b exp 0", i, out_valid); end
      in_valid = 1'b0;
      step();
      n_checks++; if (out_valid !== 1'b1 || out_data !== vexp[i]) begin n_fail++; $display("FAIL round_data %0d: got valid=%b data=%0d exp 1/%0d", i, out_valid, out_data, vexp[i]); end
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL round_pop %0d: got valid=%b exp 0", i, out_valid); end
      step();
      for (int j = 0; j < 3; j++) begin
        in_valid = 1'b1; y_in = Y_MAX;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL round_skip %0d/%0d: got valid=%b exp 0", i, j, out_valid); end
      end
    end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL round_no_sat: got %b exp 0", sat_flag); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_valid = 1'b1; y_in = Y_MAX;
    step();
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_set: got %b exp 1", sat_flag); end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'hFFFF) begin n_fail++; $display("FAIL sat_data: got valid=%b data=%h exp 1/ffff", out_valid, out_data); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clear: got %b exp 0", sat_flag); end
    in_valid = 1'b1; y_in = '0;
    step(); step(); step();
    y_in = Y_MAX; clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_clear_collide: got %b exp 1", sat_flag); end
    y_in = '0;
    step(); step(); step();
    in_valid = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    n_checks++; if (sat_flag !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_drain: got sat=%b valid=%b exp 0/0", sat_flag, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      in_valid = 1'b1; y_in = 34'(256 * n);
      step();
      y_in = '0;
      step(); step(); step();
    end
    in_valid = 1'b0;
    step(); step();
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d exp 4", fifo_count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b exp 1", overflow); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'd1) begin n_fail++; $display("FAIL bp_head: got valid=%b data=%0d exp 1/1", out_valid, out_data); end
    out_ready = 1'b1;
    for (int n = 2; n <= 4; n++) begin
      step();
      n_checks++; if (out_data !== 16'(n)) begin n_fail++; $display("FAIL bp_pop %0d: got %0d exp %0d", n, out_data, n); end
    end
    step();
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'd0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL bp_empty: got valid=%b data=%0d count=%0d exp 0/0/0", out_valid, out_data, fifo_count); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_clear: got %b exp 0", overflow); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      in_valid = 1'b1; y_in = 34'(256 * n);
      step();
      y_in = '0;
      step(); step(); step();
    end
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d exp 4", fifo_count); end
    y_in = 34'(256 * 5);
    step();
    n_checks++; if (fifo_count !== 3'd4 || out_data !== 16'd1) begin n_fail++; $display("FAIL full_pre: got count=%0d data=%0d exp 4/1", fifo_count, out_data); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop: got count=%0d ovf=%b exp 4/0", fifo_count, overflow); end
    n_checks++; if (out_data !== 16'd2) begin n_fail++; $display("FAIL full_head: got %0d exp 2", out_data); end
    for (int n = 3; n <= 5; n++) begin
      step();
      n_checks++; if (out_data !== 16'(n)) begin n_fail++; $display("FAIL full_pop %0d: got %0d exp %0d", n, out_data, n); end
    end
    step();
    n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL full_empty: got valid=%b count=%0d exp 0/0", out_valid, fifo_count); end
  endtask

  task automatic test_reset_mid();
    logic [33:0] vin [3] = '{Y_MAX, 34'd512, 34'd768};
    reset = 1'b0;
    step();
    reset = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; y_in = vin[i];
      step();
      y_in = '0;
      step(); step(); step();
    end
    y_in = 34'd1024;
    step();
    in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd3 || sat_flag !== 1'b1 || out_data !== 16'hFFFF) begin n_fail++; $display("FAIL mid_setup: got count=%0d sat=%b data=%h exp 3/1/ffff", fifo_count, sat_flag, out_data); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'd0) begin n_fail++; $display("FAIL mid_async_out: got valid=%b data=%0d exp 0/0", out_valid, out_data); end
    n_checks++; if (fifo_count !== 3'd0 || sat_flag !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_async_state: got count=%0d sat=%b ovf=%b exp 0/0/0", fifo_count, sat_flag, overflow); end
    step();
    reset = 1'b1;
    in_valid = 1'b1; y_in = 34'(256 * 7);
    step();
    y_in = 34'(256 * 9);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_s1_flushed: got valid=%b exp 0", out_valid); end
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'd7) begin n_fail++; $display("FAIL mid_first_kept: got valid=%b data=%0d exp 1/7", out_valid, out_data); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
